// File: rtl/dvp_pkg.sv
// Shared FSM state type and RGB565 colour-bar constants for the DVP frame emulator.
// Latency: n/a (types, constants and one combinational lookup).
// Backpressure: none; the DVP stream is free-running.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_SOLID = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // Colour bars, left to right, in RGB565
    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Test-pattern pixel generator: maps (x, y, pattern, frame value) to one RGB565 pixel.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller samples the pixel whenever it needs it.
module dvp_pattern_gen #(
    parameter int H_ACT = 640
) (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [1:0]  pattern_i,
    input  logic [15:0] frame_i,
    output logic [15:0] pixel_o
);
    import dvp_pkg::*;

    localparam logic [15:0] BAR_W = 16'(H_ACT / 8);

    logic [15:0] bar_idx;
    logic        unused_bits;

    assign bar_idx     = x_i / BAR_W;
    // Only bar index 0..7 and bit 3 of y are meaningful; the rest are tied off here.
    assign unused_bits = ^{bar_idx[15:3], y_i[15:4], y_i[2:0]};

    // Select the pixel for the current coordinate and pattern.
    always_comb begin
        pixel_o = 16'h0000;
        case (pattern_i)
            PAT_BARS:  pixel_o = bar_colour(bar_idx[2:0]);
            PAT_RAMP:  pixel_o = x_i;
            PAT_SOLID: pixel_o = frame_i;
            default:   pixel_o = (x_i[3] ^ y_i[3]) ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvp_frame_emu.sv
// DVP camera emulator: free-running vsync/href/byte timing with selectable RGB565 test patterns.
// Latency: all outputs registered; they reflect the FSM state entered on the same clock edge.
// Backpressure: none; a started frame always runs to completion unless reset.
module dvp_frame_emu #(
    parameter int H_ACT     = 640,
    parameter int V_ACT     = 480,
    parameter int H_BLANK   = 160,
    parameter int VS_LINES  = 4,
    parameter int VBP_LINES = 16,
    parameter int VFP_LINES = 8
) (
    input  logic        cmos_pclk,
    input  logic        I_rst_n,
    input  logic        I_en,
    input  logic [1:0]  I_pattern,
    output logic        O_vsync,
    output logic        O_href,
    output logic [7:0]  O_data,
    output logic [15:0] O_frame_cnt,
    output logic        O_busy
);
    import dvp_pkg::*;

    localparam int LINE  = 2 * H_ACT + H_BLANK;
    localparam int VA    = (V_ACT > VS_LINES) ? V_ACT : VS_LINES;
    localparam int VB    = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
    localparam int V_MAX = (VA > VB) ? VA : VB;
    localparam int HW    = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    localparam logic [HW-1:0] H_LAST    = HW'(LINE - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(2 * H_ACT);
    localparam logic [VW-1:0] VS_LAST   = VW'(VS_LINES - 1);
    localparam logic [VW-1:0] VBP_LAST  = VW'(VBP_LINES - 1);
    localparam logic [VW-1:0] ACT_LAST  = VW'(V_ACT - 1);
    localparam logic [VW-1:0] VFP_LAST  = VW'(VFP_LINES - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [VW-1:0] v_last;
    logic [15:0]   frame_q, frame_d;
    logic [1:0]    pat_q;
    logic [15:0]   solid_q;
    logic          line_end;
    logic          frame_start;

    logic          vsync_q, href_q, busy_q;
    logic [7:0]    data_q;
    logic          href_d;
    logic [7:0]    data_d;
    logic [15:0]   x_pix, y_pix, pixel;

    assign line_end    = (hcnt_q == H_LAST);
    assign frame_start = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);

    // Next-state logic: H counter runs every cycle, V counter and state advance only at line end.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        frame_d = frame_q;
        v_last  = '0;
        case (state_q)
            ST_VSYNC:  v_last = VS_LAST;
            ST_VBP:    v_last = VBP_LAST;
            ST_ACTIVE: v_last = ACT_LAST;
            ST_VFP:    v_last = VFP_LAST;
            default:   v_last = '0;
        endcase
        if (state_q == ST_IDLE) begin
            if (I_en) begin
                state_d = ST_VSYNC;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        end else if (line_end) begin
            hcnt_d = '0;
            if (vcnt_q == v_last) begin
                vcnt_d = '0;
                case (state_q)
                    ST_VSYNC:  state_d = ST_VBP;
                    ST_VBP:    state_d = ST_ACTIVE;
                    ST_ACTIVE: state_d = ST_VFP;
                    default: begin
                        // End of front porch: the frame is complete.
                        frame_d = frame_q + 16'd1;
                        state_d = I_en ? ST_VSYNC : ST_IDLE;
                    end
                endcase
            end else begin
                vcnt_d = vcnt_q + 1'b1;
            end
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    // Pixel coordinate follows the next-state counters so data lines up with the registered href.
    assign x_pix = 16'(hcnt_d >> 1);
    assign y_pix = 16'(vcnt_d);

    dvp_pattern_gen #(
        .H_ACT(H_ACT)
    ) u_pattern_gen (
        .x_i      (x_pix),
        .y_i      (y_pix),
        .pattern_i(pat_q),
        .frame_i  (solid_q),
        .pixel_o  (pixel)
    );

    // High byte {R,G[5:3]} on even cycles, low byte {G[2:0],B} on odd cycles; zero outside href.
    assign href_d = (state_d == ST_ACTIVE) && (hcnt_d < H_ACT_END);
    assign data_d = !href_d ? 8'h00 : (hcnt_d[0] ? pixel[7:0] : pixel[15:8]);

    // FSM, counters, frame count and per-frame pattern/solid latches.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            frame_q <= '0;
            pat_q   <= '0;
            solid_q <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            frame_q <= frame_d;
            if (frame_start) begin
                pat_q   <= I_pattern;
                solid_q <= frame_d;
            end
        end
    end

    // Output registers, all updated on the edge that enters the corresponding state.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            vsync_q <= (state_d == ST_VSYNC);
            href_q  <= href_d;
            data_q  <= data_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign O_vsync     = vsync_q;
    assign O_href      = href_q;
    assign O_data      = data_q;
    assign O_frame_cnt = frame_q;
    assign O_busy      = busy_q;

endmodule

// File: doc/dvp_frame_emu.md
DVP_FRAME_EMU -- requirements
Module: dvp_frame_emu

Interface
REQ-001 SHALL have parameter H_ACT, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 160: pclk cycles with href low after each active line.
REQ-004 SHALL have parameters VS_LINES, default 4; VBP_LINES, default 16; VFP_LINES, default 8: line counts of vsync, back porch and front porch.
REQ-005 SHALL have port cmos_pclk, input, 1: pixel byte clock; all logic on its rising edge.
REQ-006 SHALL have port I_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port I_en, input, 1: run enable.
REQ-008 SHALL have port I_pattern, input, 2: 0 colour bars, 1 column ramp, 2 frame-count solid, 3 8x8 checker.
REQ-009 SHALL have port O_vsync, output, 1: frame sync, active high.
REQ-010 SHALL have port O_href, output, 1: byte-valid line reference.
REQ-011 SHALL have port O_data, output, 8: DVP byte.
REQ-012 SHALL have port O_frame_cnt, output, 16: completed-frame count.
REQ-013 SHALL have port O_busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-014 SHALL emit RGB565 pixels as two bytes, {R[4:0],G[5:3]} first and {G[2:0],B[4:0]} second, matching what the capture side reassembles.
REQ-015 SHALL run an FSM with states IDLE, VSYNC, VBP, ACTIVE and VFP; every line lasts LINE = 2*H_ACT + H_BLANK cycles in every state except IDLE.
REQ-016 SHALL leave IDLE for VSYNC on the first edge with I_en=1, with H and V counters cleared.
REQ-017 SHALL follow the sequence VSYNC (VS_LINES) -> VBP (VBP_LINES) -> ACTIVE (V_ACT) -> VFP (VFP_LINES), changing state only at line end.
REQ-018 SHALL, at VFP end, increment O_frame_cnt (wrapping 0xFFFF->0), then go to VSYNC if I_en=1, else to IDLE.
REQ-019 SHALL drive O_vsync high for exactly the VSYNC state and low otherwise.
REQ-020 SHALL, in ACTIVE, drive O_href high for hcnt 0..2*H_ACT-1 and low for the remaining H_BLANK cycles of each line.
REQ-021 SHALL drive O_data to 0x00 whenever O_href is low.
REQ-022 SHALL register all outputs; O_href and O_data change together on the same edge.
REQ-023 SHALL sample I_pattern only on entry to VSYNC, so a change mid-frame takes effect on the next frame.
REQ-024 SHALL ignore I_en deassertion mid-frame: the current frame completes first (REQ-018).
REQ-025 SHALL produce colour bars as 8 equal bars of H_ACT/8 pixels: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-026 SHALL produce the ramp as pixel = x[15:0] for column index x.
REQ-027 SHALL produce the solid pattern as pixel = O_frame_cnt value latched at VSYNC entry.
REQ-028 SHALL produce the checker as pixel = FFFF if x[3]^y[3] is 1, else 0000, where y is the active line index.
REQ-029 SHALL size counters by $clog2 of the maximum value; H_ACT not divisible by 8 is unsupported.

Reset
REQ-030 SHALL, while I_rst_n=0, hold state IDLE, all counters 0, and O_vsync=0, O_href=0, O_data=0x00, O_frame_cnt=0, O_busy=0.
REQ-031 SHALL, on reset mid-frame, abort immediately with no partial-line completion; after release, restart per REQ-016.

Structure
REQ-032 SHALL place the FSM state enum and the 8 bar colour constants in shared package dvp_pkg.
REQ-033 SHALL implement pixel generation as one sub-module, dvp_pattern_gen (inputs x, y, pattern, frame value; output 16-bit pixel); timing, FSM and byte serialisation stay in dvp_frame_emu.

Verification (parameters H_ACT=8, V_ACT=4, H_BLANK=4, VS=2, VBP=2, VFP=2; LINE=20, frame=200 cycles)
REQ-034 SHALL check: I_en=1 held -> vsync high 40 cycles, 40 cycles low, then 4 lines of href high 16 / low 4, 40 cycles low, next vsync 200 cycles after the first.
REQ-035 SHALL check: pattern 0 -> line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
REQ-036 SHALL check: pattern 1 -> bytes 00 00 00 01 ... 00 07; O_data=00 during blanking.
REQ-037 SHALL check: I_en dropped at active line 1 -> frame completes, O_frame_cnt 0->1, O_busy falls at frame end, no further vsync.
REQ-038 SHALL check: I_pattern 0->2 mid-frame -> current frame stays bars; next frame is solid 0x0001 (bytes 00 01).
REQ-039 SHALL check: I_rst_n pulsed low mid-line -> all outputs 0 on the same edge; after release, vsync restarts on the first edge with I_en=1.
